// File: rtl/tlc_pkg.sv
// Shared types and helpers for the multi-phase traffic controller.
//   tlc_state_e : phase FSM state encoding
//   tlc_tw()    : timer width that holds the longest phase count
//   Lamp*       : lamp drive levels
package tlc_pkg;

   typedef enum logic [1:0] {
      StAllRed = 2'd0,
      StGreen  = 2'd1,
      StYellow = 2'd2,
      StFlash  = 2'd3
   } tlc_state_e;

   localparam logic LampOn  = 1'b1;
   localparam logic LampOff = 1'b0;

   function automatic int unsigned tlc_tw(input int unsigned t_green,
                                          input int unsigned t_min_green,
                                          input int unsigned t_yellow,
                                          input int unsigned t_allred,
                                          input int unsigned t_flash);
      int unsigned m;
      m = t_green;
      if (t_min_green > m) m = t_min_green;
      if (t_yellow > m) m = t_yellow;
      if (t_allred > m) m = t_allred;
      if (t_flash > m) m = t_flash;
      // The +1 bit also covers the 2*T_FLASH-1 flash wrap point.
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts cycles elapsed in the current phase.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : advance enable; 0 holds the count
//   clear_i       : restart from 0 on the next enabled cycle
//   len_i         : current phase length
//   count_o       : cycles elapsed in phase
//   last_o        : count_o is the final cycle of the phase
module tlc_phase_timer #(
   parameter int unsigned TW = 7
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          clear_i,
   input  logic [TW-1:0] len_i,
   output logic [TW-1:0] count_o,
   output logic          last_o
);

   logic [TW-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = clear_i ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == len_i - 1'b1);

endmodule

// File: rtl/tlc_multi_phase_ctrl.sv
// Multi-channel traffic-phase controller: GREEN -> YELLOW -> ALL-RED per channel,
// with demand calls cutting green short and a flashing-red fail-safe mode.
//   blif_clk_net, blif_reset_net : clock, async active-low reset
//   en_i       : advance enable (0 freezes everything)
//   call_i     : per-channel demand calls
//   flash_i    : request flashing-red mode
//   grn_o, ylw_o, red_o : lamp drives
//   ch_o       : channel currently served
//   timer_o    : cycles elapsed in current phase
//   cyc_done_o : pulse when the last channel finishes yellow
module tlc_multi_phase_ctrl
   import tlc_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned T_GREEN     = 40,
   parameter int unsigned T_MIN_GREEN = 8,
   parameter int unsigned T_YELLOW    = 6,
   parameter int unsigned T_ALLRED    = 3,
   parameter int unsigned T_FLASH     = 4,
   localparam int unsigned TW = tlc_tw(T_GREEN, T_MIN_GREEN, T_YELLOW, T_ALLRED, T_FLASH),
   localparam int unsigned CW = $clog2(NUM_CH)
) (
   input  logic              blif_clk_net,
   input  logic              blif_reset_net,
   input  logic              en_i,
   input  logic [NUM_CH-1:0] call_i,
   input  logic              flash_i,
   output logic [NUM_CH-1:0] grn_o,
   output logic [NUM_CH-1:0] ylw_o,
   output logic [NUM_CH-1:0] red_o,
   output logic [CW-1:0]     ch_o,
   output logic [TW-1:0]     timer_o,
   output logic              cyc_done_o
);

   localparam logic [TW-1:0] LenGreen    = TW'(T_GREEN);
   localparam logic [TW-1:0] LenYellow   = TW'(T_YELLOW);
   localparam logic [TW-1:0] LenAllRed   = TW'(T_ALLRED);
   localparam logic [TW-1:0] LenFlash    = TW'(2 * T_FLASH);
   localparam logic [TW-1:0] FlashHalf   = TW'(T_FLASH);
   localparam logic [TW-1:0] MinGreenM1  = TW'(T_MIN_GREEN - 1);
   localparam logic [CW-1:0] LastCh      = CW'(NUM_CH - 1);

   tlc_state_e        state_d, state_q;
   logic [CW-1:0]     ch_d, ch_q;
   logic [NUM_CH-1:0] pend_d, pend_q;
   logic              cyc_done_d, cyc_done_q;

   logic [NUM_CH-1:0] ch_oh;
   logic [NUM_CH-1:0] call_mask;
   logic              pend_other;
   logic [TW-1:0]     phase_len;
   logic [TW-1:0]     count;
   logic              last;
   logic              clear;

   assign ch_oh      = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_q;
   assign pend_other = |(pend_q & ~ch_oh);

   always_comb begin
      phase_len = LenAllRed;
      unique case (state_q)
         StAllRed: phase_len = LenAllRed;
         StGreen:  phase_len = LenGreen;
         StYellow: phase_len = LenYellow;
         StFlash:  phase_len = LenFlash;
         default:  phase_len = LenAllRed;
      endcase
   end

   tlc_phase_timer #(
      .TW(TW)
   ) u_timer (
      .clk_i  (blif_clk_net),
      .rst_ni (blif_reset_net),
      .en_i   (en_i),
      .clear_i(clear),
      .len_i  (phase_len),
      .count_o(count),
      .last_o (last)
   );

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      pend_d     = pend_q;
      cyc_done_d = cyc_done_q;
      clear      = 1'b0;
      call_mask  = call_i;
      if (state_q == StGreen) call_mask = call_i & ~ch_oh;
      if (en_i) begin
         cyc_done_d = 1'b0;
         if (state_q != StFlash) pend_d = pend_q | call_mask;
         unique case (state_q)
            StAllRed: begin
               if (last) begin
                  clear = 1'b1;
                  if (flash_i) begin
                     state_d = StFlash;
                  end else begin
                     state_d = StGreen;
                     // Entering green serves this channel's call.
                     pend_d  = pend_d & ~ch_oh;
                  end
               end
            end
            StGreen: begin
               if (last || flash_i || (pend_other && (count >= MinGreenM1))) begin
                  clear   = 1'b1;
                  state_d = StYellow;
               end
            end
            StYellow: begin
               if (last) begin
                  clear      = 1'b1;
                  state_d    = StAllRed;
                  cyc_done_d = (ch_q == LastCh);
                  ch_d       = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
               end
            end
            StFlash: begin
               if (!flash_i) begin
                  clear   = 1'b1;
                  state_d = StAllRed;
                  ch_d    = '0;
               end else if (last) begin
                  clear = 1'b1;
               end
            end
            default: state_d = StAllRed;
         endcase
      end
   end

   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         state_q    <= StAllRed;
         ch_q       <= '0;
         pend_q     <= '0;
         cyc_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         pend_q     <= pend_d;
         cyc_done_q <= cyc_done_d;
      end
   end

   // Lamps decode straight from registered state, channel and timer.
   always_comb begin
      grn_o = {NUM_CH{LampOff}};
      ylw_o = {NUM_CH{LampOff}};
      red_o = {NUM_CH{LampOn}};
      unique case (state_q)
         StGreen: begin
            grn_o = ch_oh;
            red_o = ~ch_oh;
         end
         StYellow: begin
            ylw_o = ch_oh;
            red_o = ~ch_oh;
         end
         StFlash: red_o = (count < FlashHalf) ? {NUM_CH{LampOn}} : {NUM_CH{LampOff}};
         default: ;
      endcase
   end

   assign ch_o       = ch_q;
   assign timer_o    = count;
   assign cyc_done_o = cyc_done_q;

endmodule

// File: tb/tb_tlc_multi_phase_ctrl.sv
module tb_tlc_multi_phase_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] call;
   logic       flash;
   logic [1:0] grn, ylw, red;
   logic       ch;
   logic [6:0] timer;
   logic       cyc;

   int checks = 0;
   int errors = 0;
   int mon_lim;

   tlc_multi_phase_ctrl dut (
      .blif_clk_net  (clk),
      .blif_reset_net(rst_n),
      .en_i          (en),
      .call_i        (call),
      .flash_i       (flash),
      .grn_o         (grn),
      .ylw_o         (ylw),
      .red_o         (red),
      .ch_o          (ch),
      .timer_o       (timer),
      .cyc_done_o    (cyc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] g, input logic [1:0] y,
                      input logic [1:0] r, input logic c, input int t, input logic cd);
      logic [14:0] obs, exp;
      obs = {grn, ylw, red, ch, timer, cyc};
      exp = {g, y, r, c, 7'(t), cd};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed g=%b y=%b r=%b ch=%b t=%0d cyc=%b expected g=%b y=%b r=%b ch=%b t=%0d cyc=%b",
                tag, obs[14:13], obs[12:11], obs[10:9], obs[8], obs[7:1], obs[0],
                g, y, r, c, t, cd);
      end
   endtask

   // Lamp and timer invariants every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         assert ($onehot0(grn | ylw)) else begin
            errors++;
            $error("FAIL onehot0 observed=%b expected at most one bit", grn | ylw);
         end
         checks++;
         assert ((grn & red) === 2'b00) else begin
            errors++;
            $error("FAIL grn_and_red observed=%b expected=00", grn & red);
         end
         if (grn != 2'b00) mon_lim = 40;
         else if (ylw != 2'b00) mon_lim = 6;
         else mon_lim = 8;
         checks++;
         assert (int'(timer) < mon_lim) else begin
            errors++;
            $error("FAIL timer_range observed=%0d expected below %0d", timer, mon_lim);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      call  = 2'b00;
      flash = 1'b0;
      #2;
      chk("reset", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      #1;

      // Free-running sequence
      chk("s1_ar0", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b0);
      run(3);  chk("s1_g0_start", 2'b01, 2'b00, 2'b10, 1'b0, 0, 1'b0);
      run(39); chk("s1_g0_end", 2'b01, 2'b00, 2'b10, 1'b0, 39, 1'b0);
      run(1);  chk("s1_y0_start", 2'b00, 2'b01, 2'b10, 1'b0, 0, 1'b0);
      run(6);  chk("s1_ar_ch1", 2'b00, 2'b00, 2'b11, 1'b1, 0, 1'b0);
      run(3);  chk("s1_g1_start", 2'b10, 2'b00, 2'b01, 1'b1, 0, 1'b0);
      run(40); chk("s1_y1_start", 2'b00, 2'b10, 2'b01, 1'b1, 0, 1'b0);
      run(5);  chk("s1_y1_end", 2'b00, 2'b10, 2'b01, 1'b1, 5, 1'b0);
      run(1);  chk("s1_cyc_done_98", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b1);
      run(1);  chk("s1_cyc_clear", 2'b00, 2'b00, 2'b11, 1'b0, 1, 1'b0);

      // One-cycle call on channel 1 cuts G0 at min green
      run(2);  chk("s2_g0", 2'b01, 2'b00, 2'b10, 1'b0, 0, 1'b0);
      run(2);
      call = 2'b10;
      run(1);
      call = 2'b00;
      run(4);  chk("s2_g0_cut_t7", 2'b01, 2'b00, 2'b10, 1'b0, 7, 1'b0);
      run(1);  chk("s2_y0", 2'b00, 2'b01, 2'b10, 1'b0, 0, 1'b0);
      run(9);  chk("s2_g1", 2'b10, 2'b00, 2'b01, 1'b1, 0, 1'b0);
      run(39); chk("s2_g1_full", 2'b10, 2'b00, 2'b01, 1'b1, 39, 1'b0);
      run(7);  chk("s2_cyc", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b1);
      run(3);  chk("s2_g0_again", 2'b01, 2'b00, 2'b10, 1'b0, 0, 1'b0);

      // Call on the green channel itself has no effect
      call = 2'b01;
      run(39); chk("s3_g0_full", 2'b01, 2'b00, 2'b10, 1'b0, 39, 1'b0);
      run(1);
      call = 2'b00;
      chk("s3_y0", 2'b00, 2'b01, 2'b10, 1'b0, 0, 1'b0);
      run(48); chk("s3_g1_full", 2'b10, 2'b00, 2'b01, 1'b1, 39, 1'b0);
      run(10); chk("s3_g0", 2'b01, 2'b00, 2'b10, 1'b0, 0, 1'b0);

      // Flash request mid-green
      run(20);
      flash = 1'b1;
      run(1);  chk("s4_y0", 2'b00, 2'b01, 2'b10, 1'b0, 0, 1'b0);
      run(6);  chk("s4_ar", 2'b00, 2'b00, 2'b11, 1'b1, 0, 1'b0);
      run(3);  chk("s4_flash_on", 2'b00, 2'b00, 2'b11, 1'b1, 0, 1'b0);
      call = 2'b10;
      run(3);  chk("s4_flash_on_end", 2'b00, 2'b00, 2'b11, 1'b1, 3, 1'b0);
      run(1);  chk("s4_flash_off", 2'b00, 2'b00, 2'b00, 1'b1, 4, 1'b0);
      run(3);  chk("s4_flash_off_end", 2'b00, 2'b00, 2'b00, 1'b1, 7, 1'b0);
      run(1);  chk("s4_flash_wrap", 2'b00, 2'b00, 2'b11, 1'b1, 0, 1'b0);
      flash = 1'b0;
      call  = 2'b00;
      run(1);  chk("s4_exit", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b0);
      run(11); chk("s4_call_ignored", 2'b01, 2'b00, 2'b10, 1'b0, 8, 1'b0);

      // Enable freeze mid-yellow
      run(34); chk("s5_y0", 2'b00, 2'b01, 2'b10, 1'b0, 2, 1'b0);
      en = 1'b0;
      run(10); chk("s5_frozen", 2'b00, 2'b01, 2'b10, 1'b0, 2, 1'b0);
      en = 1'b1;
      run(3);  chk("s5_y0_end", 2'b00, 2'b01, 2'b10, 1'b0, 5, 1'b0);
      run(1);  chk("s5_ar", 2'b00, 2'b00, 2'b11, 1'b1, 0, 1'b0);

      // Asynchronous reset during G1
      run(18); chk("s6_g1_t15", 2'b10, 2'b00, 2'b01, 1'b1, 15, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("s6_async_reset", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("s6_release", 2'b00, 2'b00, 2'b11, 1'b0, 0, 1'b0);
      run(3);  chk("s6_g0", 2'b01, 2'b00, 2'b10, 1'b0, 0, 1'b0);
      run(40); chk("s6_y0", 2'b00, 2'b01, 2'b10, 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
